// File: rtl/arb_fifo_queue.sv
`default_nettype none
// ============================================================================
// Module      : arb_fifo_queue
// Description : Arrival-ordered REQ# queue feeding the PCI arbiter grant stage.
// Revision    : 1.0 - initial release
// ============================================================================

module arb_fifo_queue #(
  parameter int N_DEV = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_DEV-1:0]           req_n,
  input  logic                       done,
  output logic [$clog2(N_DEV)-1:0]   head_idx,
  output logic                       head_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int c_IDX_W = $clog2(N_DEV);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_CHECK = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [c_IDX_W-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [N_DEV-1:0]     r_queued;
  logic [c_IDX_W-1:0]   r_head_idx;
  logic                 r_head_valid;
  logic                 r_full;

  logic [N_DEV-1:0]     w_avail;
  logic                 w_enq;
  logic [c_IDX_W-1:0]   w_cand;
  logic [c_IDX_W-1:0]   w_head;
  logic                 w_pop;
  logic [c_CNT_W-1:0]   w_count_nxt;
  logic [N_DEV-1:0]     w_queued_nxt;

  // A device is eligible only while it requests and holds no entry yet.
  assign w_avail = ~req_n & ~r_queued;
  assign w_head  = r_mem[r_rd_ptr];

  always_comb begin
    w_enq  = 1'b0;
    w_cand = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (w_avail[i]) begin
        w_enq  = 1'b1;
        w_cand = c_IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;

    case (r_state)
      S_EMPTY: begin
        if (w_enq) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (req_n[w_head]) begin
          w_pop = 1'b1;
        end else begin
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (done) begin
          w_pop = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase

    w_count_nxt = r_count + {{(c_CNT_W-1){1'b0}}, w_enq}
                          - {{(c_CNT_W-1){1'b0}}, w_pop};

    if (w_pop) begin
      w_state_nxt = (w_count_nxt != '0) ? S_CHECK : S_EMPTY;
    end
  end

  // A popped device cannot be re-picked this cycle: its queued bit is still set.
  always_comb begin
    w_queued_nxt = r_queued;
    if (w_enq) begin
      w_queued_nxt[w_cand] = 1'b1;
    end
    if (w_pop) begin
      w_queued_nxt[w_head] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= w_cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_queued     <= '0;
      r_head_idx   <= '0;
      r_head_valid <= 1'b0;
      r_full       <= 1'b0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + {{(c_PTR_W-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(c_PTR_W-1){1'b0}}, 1'b1};
      end
      r_count      <= w_count_nxt;
      r_queued     <= w_queued_nxt;
      r_full       <= (w_count_nxt == c_CNT_W'(DEPTH));
      r_head_valid <= (w_state_nxt == S_GRANT);
      r_head_idx   <= (w_state_nxt == S_GRANT) ? w_head : '0;
    end
  end

  assign head_idx   = r_head_idx;
  assign head_valid = r_head_valid;
  assign count      = r_count;
  assign full       = r_full;

endmodule

`default_nettype wire

// File: tb/tb_arb_fifo_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_fifo_queue
// Description : Directed self-checking bench for arb_fifo_queue.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_arb_fifo_queue;

  logic       clk;
  logic       rst;
  logic [7:0] req_n;
  logic       done;
  logic [2:0] head_idx;
  logic       head_valid;
  logic [3:0] count;
  logic       full;

  int n_tests;
  int n_fail;
  int simul_order [4] = '{0, 2, 5, 7};

  arb_fifo_queue #(
    .N_DEV(8),
    .DEPTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_n     (req_n),
    .done      (done),
    .head_idx  (head_idx),
    .head_valid(head_valid),
    .count     (count),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_n = 8'hFF;
    done  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (head_idx !== 3'd0) begin
      n_fail++; $display("FAIL reset_head_idx: got %0d expected 0", head_idx);
    end
    n_tests++;
    if (head_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_head_valid: got %0b expected 0", head_valid);
    end
    n_tests++;
    if (count !== 4'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", count);
    end
    n_tests++;
    if (full !== 1'b0) begin
      n_fail++; $display("FAIL reset_full: got %0b expected 0", full);
    end
  endtask

  // done held high through EMPTY and CHECK must be ignored.
  task automatic test_single();
    do_reset();
    req_n = 8'hF7;
    done  = 1'b1;
    step();
    n_tests++;
    if (count !== 4'd1 || head_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_enq: count=%0d valid=%0b expected 1/0", count, head_valid);
    end
    step();
    done = 1'b0;
    n_tests++;
    if (head_valid !== 1'b1 || head_idx !== 3'd3 || count !== 4'd1) begin
      n_fail++; $display("FAIL single_grant: valid=%0b idx=%0d count=%0d expected 1/3/1",
                         head_valid, head_idx, count);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    n_tests++;
    if (head_valid !== 1'b0 || count !== 4'd0) begin
      n_fail++; $display("FAIL single_pop: valid=%0b count=%0d expected 0/0", head_valid, count);
    end
    step();
    n_tests++;
    if (head_valid !== 1'b0 || count !== 4'd1) begin
      n_fail++; $display("FAIL single_reenq: valid=%0b count=%0d expected 0/1", head_valid, count);
    end
    step();
    n_tests++;
    if (head_valid !== 1'b1 || head_idx !== 3'd3) begin
      n_fail++; $display("FAIL single_regrant: valid=%0b idx=%0d expected 1/3", head_valid, head_idx);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_n = 8'h5A;
    for (int e = 1; e <= 4; e++) begin
      step();
      n_tests++;
      if (count !== 4'(e)) begin
        n_fail++; $display("FAIL simul_count_%0d: got %0d expected %0d", e, count, e);
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (head_valid !== 1'b1 || head_idx !== 3'(simul_order[k])) begin
        n_fail++; $display("FAIL simul_grant_%0d: valid=%0b idx=%0d expected 1/%0d",
                           k, head_valid, head_idx, simul_order[k]);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      n_tests++;
      if (head_valid !== 1'b0) begin
        n_fail++; $display("FAIL simul_dead_%0d: valid=%0b expected 0", k, head_valid);
      end
      step();
    end
  endtask

  task automatic test_arrival_order();
    do_reset();
    req_n = 8'hBF;
    step();
    step();
    step();
    step();
    req_n = 8'hBD;
    step();
    n_tests++;
    if (head_idx !== 3'd6 || head_valid !== 1'b1) begin
      n_fail++; $display("FAIL arrival_first: idx=%0d valid=%0b expected 6/1", head_idx, head_valid);
    end
    step();
    n_tests++;
    if (count !== 4'd2) begin
      n_fail++; $display("FAIL arrival_count: got %0d expected 2", count);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    n_tests++;
    if (head_idx !== 3'd1 || head_valid !== 1'b1 || count !== 4'd2) begin
      n_fail++; $display("FAIL arrival_second: idx=%0d valid=%0b count=%0d expected 1/1/2",
                         head_idx, head_valid, count);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    req_n = 8'hFB;
    step();
    req_n = 8'hEB;
    step();
    step();
    req_n = 8'hFB;
    step();
    n_tests++;
    if (head_idx !== 3'd2 || count !== 4'd2) begin
      n_fail++; $display("FAIL withdraw_pre: idx=%0d count=%0d expected 2/2", head_idx, count);
    end
    req_n = 8'hFF;
    done  = 1'b1;
    step();
    done = 1'b0;
    n_tests++;
    if (head_valid !== 1'b0 || count !== 4'd1) begin
      n_fail++; $display("FAIL withdraw_pop: valid=%0b count=%0d expected 0/1", head_valid, count);
    end
    step();
    n_tests++;
    if (head_valid !== 1'b0 || count !== 4'd0) begin
      n_fail++; $display("FAIL withdraw_discard: valid=%0b count=%0d expected 0/0", head_valid, count);
    end
    step();
    n_tests++;
    if (head_valid !== 1'b0 || count !== 4'd0) begin
      n_fail++; $display("FAIL withdraw_idle: valid=%0b count=%0d expected 0/0", head_valid, count);
    end
    req_n = 8'hEF;
    step();
    n_tests++;
    if (count !== 4'd1) begin
      n_fail++; $display("FAIL withdraw_requeue: count=%0d expected 1", count);
    end
    step();
    n_tests++;
    if (head_valid !== 1'b1 || head_idx !== 3'd4) begin
      n_fail++; $display("FAIL withdraw_regrant: valid=%0b idx=%0d expected 1/4", head_valid, head_idx);
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    req_n = 8'h00;
    for (int e = 1; e <= 8; e++) begin
      step();
    end
    n_tests++;
    if (count !== 4'd8 || full !== 1'b1 || head_idx !== 3'd0) begin
      n_fail++; $display("FAIL full_fill: count=%0d full=%0b idx=%0d expected 8/1/0",
                         count, full, head_idx);
    end
    for (int g = 0; g < 20; g++) begin
      n_tests++;
      if (head_valid !== 1'b1 || head_idx !== 3'(g % 8) || count !== 4'd8 || full !== 1'b1) begin
        n_fail++; $display("FAIL wrap_grant_%0d: valid=%0b idx=%0d count=%0d full=%0b expected 1/%0d/8/1",
                           g, head_valid, head_idx, count, full, g % 8);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      n_tests++;
      if (head_valid !== 1'b0 || count !== 4'd7 || full !== 1'b0) begin
        n_fail++; $display("FAIL wrap_pop_%0d: valid=%0b count=%0d full=%0b expected 0/7/0",
                           g, head_valid, count, full);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_n = 8'hE0;
    for (int e = 1; e <= 5; e++) begin
      step();
    end
    n_tests++;
    if (count !== 4'd5 || head_valid !== 1'b1 || head_idx !== 3'd0) begin
      n_fail++; $display("FAIL areset_pre: count=%0d valid=%0b idx=%0d expected 5/1/0",
                         count, head_valid, head_idx);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (count !== 4'd0 || head_valid !== 1'b0 || head_idx !== 3'd0 || full !== 1'b0) begin
      n_fail++; $display("FAIL areset_immediate: count=%0d valid=%0b idx=%0d full=%0b expected 0/0/0/0",
                         count, head_valid, head_idx, full);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (count !== 4'd0) begin
      n_fail++; $display("FAIL areset_hold: count=%0d expected 0", count);
    end
    step();
    n_tests++;
    if (count !== 4'd1 || head_valid !== 1'b0) begin
      n_fail++; $display("FAIL areset_reenq: count=%0d valid=%0b expected 1/0", count, head_valid);
    end
    step();
    n_tests++;
    if (head_valid !== 1'b1 || head_idx !== 3'd0 || count !== 4'd2) begin
      n_fail++; $display("FAIL areset_regrant: valid=%0b idx=%0d count=%0d expected 1/0/2",
                         head_valid, head_idx, count);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    req_n   = 8'hFF;
    done    = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_arrival_order();
    test_withdraw();
    test_full_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
